// File: rtl/cpu_sequencer_if.sv
// Decoded-field inputs and phase strobes between the instruction sequencer and the CPU datapath.
interface cpu_sequencer_if;
  logic       en;
  logic [1:0] ins_byte;
  logic [1:0] ins_mode;
  logic [1:0] ins_ot;
  logic [3:0] ins_opcode;
  logic       ins_load;
  logic       ins2_load;
  logic       pc_inc;
  logic       pc_load;
  logic       op1_load;
  logic       op2_load;
  logic       ram_rd;
  logic       reg_load;
  logic       instr_done;
  logic       busy;
  logic       fault;
  logic [2:0] state;

  modport master (
    output en, ins_byte, ins_mode, ins_ot, ins_opcode,
    input  ins_load, ins2_load, pc_inc, pc_load, op1_load, op2_load,
           ram_rd, reg_load, instr_done, busy, fault, state
  );

  modport slave (
    input  en, ins_byte, ins_mode, ins_ot, ins_opcode,
    output ins_load, ins2_load, pc_inc, pc_load, op1_load, op2_load,
           ram_rd, reg_load, instr_done, busy, fault, state
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle Moore sequencer stepping fetch/decode/operand/execute/writeback
// and issuing one strobe set per phase; illegal encodings park it in a sticky fault.
module cpu_sequencer (
  input logic            clk,
  input logic            rst,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    FETCH2  = 3'd3,
    MEM     = 3'd4,
    OPERAND = 3'd5,
    EXEC    = 3'd6,
    WB      = 3'd7
  } state_t;

  state_t state_q, state_d;
  logic   fault_q, fault_d;
  logic   direct_q;
  logic   illegal;
  logic   is_jump;

  // Mode is captured at DECODE so FETCH2 does not depend on the live splitter fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fault_q  <= 1'b0;
      direct_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (state_q == DECODE)
        direct_q <= (bus.ins_mode == 2'b10);
    end
  end

  always_comb begin
    illegal = !((bus.ins_byte == 2'b01) || (bus.ins_byte == 2'b10))
            || (bus.ins_mode == 2'b11)
            || (bus.ins_ot == 2'b11)
            || ((bus.ins_mode == 2'b10) && (bus.ins_byte == 2'b01));
    is_jump = (bus.ins_ot == 2'b00) && (bus.ins_opcode == 4'hF);
  end

  // FAULT shares the IDLE encoding; the fault flag alone blocks restart.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE:    if (bus.en && !fault_q) state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE: begin
        if (illegal) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else if (bus.ins_byte == 2'b10) begin
          state_d = FETCH2;
        end else begin
          state_d = OPERAND;
        end
      end
      FETCH2:  state_d = direct_q ? MEM : OPERAND;
      MEM:     state_d = OPERAND;
      OPERAND: state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = bus.en ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ins_load   = 1'b0;
    bus.ins2_load  = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.op1_load   = 1'b0;
    bus.op2_load   = 1'b0;
    bus.ram_rd     = 1'b0;
    bus.reg_load   = 1'b0;
    bus.instr_done = 1'b0;
    unique case (state_q)
      FETCH: begin
        bus.ins_load = 1'b1;
        bus.pc_inc   = 1'b1;
      end
      FETCH2: begin
        bus.ins2_load = 1'b1;
        bus.pc_inc    = 1'b1;
      end
      MEM:     bus.ram_rd = 1'b1;
      OPERAND: begin
        bus.op1_load = 1'b1;
        bus.op2_load = 1'b1;
      end
      WB: begin
        bus.pc_load    = is_jump;
        bus.reg_load   = !is_jump;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
    bus.busy  = (state_q != IDLE);
    bus.fault = fault_q;
    bus.state = state_q;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: each instruction's expected per-cycle
// output trace is derived from its fields and compared cycle by cycle.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst;

  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Packed observation: {state[2:0], ins_load, ins2_load, pc_inc, pc_load,
  // op1_load, op2_load, ram_rd, reg_load, instr_done, busy, fault}
  localparam logic [13:0] F_FAULT = 14'd1 << 0;
  localparam logic [13:0] F_BUSY  = 14'd1 << 1;
  localparam logic [13:0] F_DONE  = 14'd1 << 2;
  localparam logic [13:0] F_REGL  = 14'd1 << 3;
  localparam logic [13:0] F_RAM   = 14'd1 << 4;
  localparam logic [13:0] F_OP2   = 14'd1 << 5;
  localparam logic [13:0] F_OP1   = 14'd1 << 6;
  localparam logic [13:0] F_PCL   = 14'd1 << 7;
  localparam logic [13:0] F_PCI   = 14'd1 << 8;
  localparam logic [13:0] F_INS2  = 14'd1 << 9;
  localparam logic [13:0] F_INS   = 14'd1 << 10;

  logic [13:0] trace[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] sample();
    return {bus.state, bus.ins_load, bus.ins2_load, bus.pc_inc, bus.pc_load,
            bus.op1_load, bus.op2_load, bus.ram_rd, bus.reg_load,
            bus.instr_done, bus.busy, bus.fault};
  endfunction

  function automatic logic [13:0] st(input int unsigned n);
    return 14'(n) << 11;
  endfunction

  function automatic bit is_legal(input logic [1:0] b, input logic [1:0] m, input logic [1:0] o);
    return ((b == 2'd1) || (b == 2'd2)) && (m != 2'd3) && (o != 2'd3)
           && !((m == 2'd2) && (b == 2'd1));
  endfunction

  // Phase list: fetch, decode, [second word], [memory read], operand, execute, writeback.
  function automatic void build_trace(input logic [1:0] b, input logic [1:0] m,
                                      input logic [1:0] o, input logic [3:0] opc);
    trace.delete();
    trace.push_back(st(1) | F_INS | F_PCI | F_BUSY);
    trace.push_back(st(2) | F_BUSY);
    if (!is_legal(b, m, o)) begin
      for (int i = 0; i < 4; i++) trace.push_back(st(0) | F_FAULT);
      return;
    end
    if (b == 2'd2) trace.push_back(st(3) | F_INS2 | F_PCI | F_BUSY);
    if (m == 2'd2) trace.push_back(st(4) | F_RAM | F_BUSY);
    trace.push_back(st(5) | F_OP1 | F_OP2 | F_BUSY);
    trace.push_back(st(6) | F_BUSY);
    trace.push_back(st(7) | F_DONE | F_BUSY |
                    (((o == 2'd0) && (opc == 4'hF)) ? F_PCL : F_REGL));
  endfunction

  task automatic do_reset(input string name);
    bus.en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, " rst_c1"}, 16'(sample()), 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check({name, " rst_c2"}, 16'(sample()), 16'd0);
  endtask

  // Called at a falling edge while the DUT is in IDLE or in WB of the previous instruction.
  task automatic run_instr(input logic [1:0] b, input logic [1:0] m, input logic [1:0] o,
                           input logic [3:0] opc, input bit keep, input string name);
    bit          legal;
    int unsigned n_inc;
    int unsigned done_at;
    logic [13:0] obs;
    legal   = is_legal(b, m, o);
    n_inc   = 0;
    done_at = 0;
    build_trace(b, m, o, opc);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.ins_byte   = b;
    bus.ins_mode   = m;
    bus.ins_ot     = o;
    bus.ins_opcode = opc;
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge clk);
      obs = sample();
      check($sformatf("%s cyc%0d", name, i + 1), 16'(obs), 16'(trace[i]));
      if (obs[8]) n_inc++;
      if (obs[2] && (done_at == 0)) done_at = i + 1;
      if (legal && (i == trace.size() - 2)) bus.en = keep;
      else if (i < trace.size() - 1)        bus.en = 1'($urandom_range(0, 1));
    end
    if (legal) begin
      check({name, " pc_inc_count"}, 16'(n_inc), (b == 2'd2) ? 16'd2 : 16'd1);
      check({name, " latency"}, 16'(done_at),
            16'(5 + ((b == 2'd2) ? 1 : 0) + ((m == 2'd2) ? 1 : 0)));
      if (!keep) begin
        @(negedge clk);
        check({name, " idle_after"}, 16'(sample()), 16'd0);
      end
    end else begin
      check({name, " no_done"}, 16'(done_at), 16'd0);
      do_reset({name, " clr"});
    end
  endtask

  initial begin
    logic [1:0] b, m, o;
    logic [3:0] opc;
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.ins_byte   = '0;
    bus.ins_mode   = '0;
    bus.ins_ot     = '0;
    bus.ins_opcode = '0;

    do_reset("init");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i), 16'(sample()), 16'd0);
    end

    run_instr(2'd1, 2'd0, 2'd1, 4'h0, 1'b1, "add_reg");
    run_instr(2'd1, 2'd1, 2'd2, 4'h3, 1'b0, "b2b_logic_imm");
    run_instr(2'd2, 2'd2, 2'd0, 4'h0, 1'b0, "mov_direct");
    run_instr(2'd1, 2'd0, 2'd0, 4'hF, 1'b0, "jump");
    run_instr(2'd2, 2'd1, 2'd0, 4'hF, 1'b1, "jump_2w");
    run_instr(2'd2, 2'd0, 2'd1, 4'h2, 1'b0, "add_2w");
    run_instr(2'd1, 2'd0, 2'd3, 4'h0, 1'b0, "ill_ot");
    run_instr(2'd0, 2'd0, 2'd0, 4'h0, 1'b0, "ill_byte");
    run_instr(2'd1, 2'd2, 2'd1, 4'h0, 1'b0, "ill_direct_1w");

    // Reset arriving in OPERAND must suppress the pending writeback.
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.ins_byte = 2'd1; bus.ins_mode = 2'd0; bus.ins_ot = 2'd1; bus.ins_opcode = 4'h1;
    @(negedge clk);
    check("rst_op fetch", 16'(sample()), 16'(st(1) | F_INS | F_PCI | F_BUSY));
    @(negedge clk);
    @(negedge clk);
    check("rst_op operand", 16'(sample()), 16'(st(5) | F_OP1 | F_OP2 | F_BUSY));
    rst    = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    check("rst_op abort", 16'(sample()), 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_op quiet%0d", i), 16'(sample()), 16'd0);
    end

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) != 0) begin
        b = 2'($urandom_range(1, 2));
        m = (b == 2'd2) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 1));
        o = 2'($urandom_range(0, 2));
        opc = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      end else begin
        b = 2'($urandom);
        m = 2'($urandom);
        o = 2'($urandom);
        opc = 4'($urandom);
      end
      run_instr(b, m, o, opc, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 16-bit CPU: a Moore state machine that steps the fetch/decode/operand/execute/writeback phases and drives the strobes for the ROM-side instruction path (PC, instruction splitter) and the datapath (Op1, Op2, RAM read, register file, PC load). It sits between the instruction splitter's decoded fields and the load/increment controls of the PC, operand, register and RAM blocks. It replaces free-running control generation with one strobe set per phase.

## Interface
- No parameters.
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; sampled only at instruction boundaries
- ins_byte  in  2  instruction length from splitter: 01 = one word, 10 = two words, others illegal
- ins_mode  in  2  addressing mode: 00 register, 01 immediate, 10 direct, 11 illegal
- ins_ot  in  2  operation type: 00 move, 01 arithmetic, 10 logic, 11 illegal
- ins_opcode  in  4  opcode; OT=00 with opcode 4'hF is a jump
- ins_load  out  1  latch ROM word into instruction splitter
- ins2_load  out  1  latch second instruction word (operand/address)
- pc_inc  out  1  increment PC
- pc_load  out  1  load PC from instruction address field (jump)
- op1_load  out  1  load Op1 from register file
- op2_load  out  1  load Op2 (register, immediate or RAM data)
- ram_rd  out  1  RAM read strobe, direct mode only
- reg_load  out  1  write ALU result to destination register
- instr_done  out  1  one-cycle pulse when an instruction retires
- busy  out  1  high in every state except IDLE and FAULT
- fault  out  1  sticky illegal-instruction flag
- state  out  3  current state encoding, for debug/verification

## Operation
- States and encoding: IDLE=0, FETCH=1, DECODE=2, FETCH2=3, MEM=4, OPERAND=5, EXEC=6, WB=7. FAULT is IDLE encoding with fault=1 (fault register distinct from state register).
- All strobes are pure decodes of the state register (Moore); at most the listed strobes are high per state, all others 0.
- IDLE: no strobes. If en=1 -> FETCH, else stay.
- FETCH: ins_load=1, pc_inc=1. -> DECODE.
- DECODE: no strobes. Checks fields: ins_byte not in {01,10}, ins_mode=11 or ins_ot=11 -> FAULT. ins_mode=10 with ins_byte=01 is illegal -> FAULT. Else ins_byte=10 -> FETCH2, else -> OPERAND.
- FETCH2: ins2_load=1, pc_inc=1. mode 10 -> MEM, else -> OPERAND.
- MEM: ram_rd=1. -> OPERAND.
- OPERAND: op1_load=1, op2_load=1. -> EXEC.
- EXEC: no strobes (ALU evaluates). -> WB.
- WB: jump (ot=00, opcode=F) asserts pc_load=1, otherwise reg_load=1; instr_done=1. en=1 -> FETCH, en=0 -> IDLE.
- FAULT: fault=1, busy=0, no strobes; held until rst, en ignored.
- en deasserted mid-instruction: current instruction completes through WB, then IDLE. No partial abort.
- Decoded fields are sampled in DECODE and WB only; they are held stable by the splitter between ins_load pulses.

## Timing
- Reset: state=IDLE, fault=0, all outputs 0 in the cycle after rst is sampled high. rst mid-instruction aborts immediately; no pending strobe issued afterwards.
- rst has priority over every transition, including FAULT exit.
- Latency from FETCH entry to instr_done: 1-word reg/imm = 5 cycles (FETCH, DECODE, OPERAND, EXEC, WB); 2-word reg/imm = 6; 2-word direct = 7.
- Back-to-back instructions with en=1: WB followed directly by FETCH, no bubble.
- IDLE->FETCH: one cycle after en sampled high.
- pc_inc pulses exactly once per instruction word; pc_load and reg_load mutually exclusive.
- Illegal instruction: fault high starting the cycle after DECODE; no op/reg/pc_load strobe for that instruction; instr_done not pulsed.

## Test plan
- Reset and idle: rst=1 for 2 cycles, en=0 -> state=0, all outputs 0, busy=0 indefinitely.
- 1-word register ADD (byte=01, mode=00, ot=01), en=1 -> strobe sequence ins_load+pc_inc, none, op1+op2_load, none, reg_load+instr_done; instr_done 5 cycles after FETCH; next cycle FETCH.
- 2-word direct move (byte=10, mode=10, ot=00, opcode=0) -> FETCH2 with ins2_load+pc_inc, MEM with ram_rd, retire at cycle 7; exactly 2 pc_inc pulses.
- Jump (ot=00, opcode=F, byte=01) -> WB asserts pc_load=1, reg_load=0.
- Illegal ot=11 -> fault=1 from cycle after DECODE, state=0, busy=0; toggling en has no effect; rst clears fault=0.
- en dropped during EXEC of a 1-word op -> WB still issues reg_load and instr_done, then IDLE; rst asserted in OPERAND -> next cycle IDLE, no reg_load.
